// File: rtl/data_mem_unit.sv
// Word-organised data memory with a fixed wait-state handshake.
// Handles sub-word loads/stores, alignment faults and range faults.
//
// state | meaning
// IDLE  | ready for a request; req_ready high once out of reset
// WAIT  | counting wait states for the accepted access
// RESP  | one-cycle response; memory was read/written on entry
module data_mem_unit #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          rdy_q;
    logic          we_q;
    logic [2:0]    funct3_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [31:0]   mem_q [DEPTH] = '{default: 32'h0};

    logic          accept;
    logic          enter_resp;
    logic          do_write;
    logic          acc_we;
    logic [2:0]    acc_funct3;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic          acc_err;
    logic          out_of_range;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_data;
    logic [3:0]    be;
    logic [31:0]   wr_data;

    assign accept = req_valid & req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign enter_resp = (state_d == RESP) && (state_q != RESP);

    // With zero wait states the access completes on the accept edge itself,
    // so the live request fields must be used instead of the latched copy.
    assign acc_we     = (state_q == IDLE) ? req_we     : we_q;
    assign acc_funct3 = (state_q == IDLE) ? req_funct3 : funct3_q;
    assign acc_addr   = (state_q == IDLE) ? req_addr   : addr_q;
    assign acc_wdata  = (state_q == IDLE) ? req_wdata  : wdata_q;

    assign out_of_range = (acc_addr[31:2] >= 30'(DEPTH));
    assign idx          = acc_addr[AW+1:2];

    always_comb begin
        acc_err = 1'b0;
        case (acc_funct3)
            3'b000:  acc_err = 1'b0;
            3'b100:  acc_err = acc_we;
            3'b001:  acc_err = acc_addr[0];
            3'b101:  acc_err = acc_we | acc_addr[0];
            3'b010:  acc_err = |acc_addr[1:0];
            default: acc_err = 1'b1;
        endcase
        if (out_of_range) begin
            acc_err = 1'b1;
        end
    end

    assign rd_word = mem_q[idx];
    assign rd_byte = rd_word[{acc_addr[1:0], 3'b000} +: 8];
    assign rd_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (acc_funct3)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_data = {24'h0, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_data = {16'h0, rd_half};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        case (acc_funct3[1:0])
            2'b00: begin
                be      = 4'b0001 << acc_addr[1:0];
                wr_data = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                be      = acc_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{acc_wdata[15:0]}};
            end
            default: begin
                be      = 4'b1111;
                wr_data = acc_wdata;
            end
        endcase
    end

    assign do_write = enter_resp & acc_we & ~acc_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            rdy_q    <= 1'b0;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= 1'b1;
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            if (enter_resp) begin
                err_q   <= acc_err;
                rdata_q <= (acc_we || acc_err) ? 32'd0 : load_data;
            end
        end
    end

    // Array contents survive reset; only the access path is cleared.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == IDLE) & rdy_q;
    assign rsp_valid = (state_q == RESP);
    assign stall     = (state_q != IDLE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: one instance with two wait states, one with none,
// both checked against a byte-addressed reference memory.
module tb_data_mem_unit;

    localparam int DEPTH_A = 1024;
    localparam int WAIT_A  = 2;
    localparam int DEPTH_B = 16;
    localparam int WAIT_B  = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_req_valid = 1'b0, a_req_we = 1'b0;
    logic [2:0]  a_req_funct3 = 3'd0;
    logic [31:0] a_req_addr = 32'd0, a_req_wdata = 32'd0;
    logic        a_req_ready, a_rsp_valid, a_rsp_err, a_stall;
    logic [31:0] a_rsp_rdata;

    logic        b_req_valid = 1'b0, b_req_we = 1'b0;
    logic [2:0]  b_req_funct3 = 3'd0;
    logic [31:0] b_req_addr = 32'd0, b_req_wdata = 32'd0;
    logic        b_req_ready, b_rsp_valid, b_rsp_err, b_stall;
    logic [31:0] b_rsp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    bit [7:0] mdl [2][4096];

    always #5 clk = ~clk;

    data_mem_unit #(.DEPTH(DEPTH_A), .WAIT_CYCLES(WAIT_A)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .stall(a_stall)
    );

    data_mem_unit #(.DEPTH(DEPTH_B), .WAIT_CYCLES(WAIT_B)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .stall(b_stall)
    );

    // Reference: byte-addressed memory, access size and sign taken from funct3.
    task automatic model_access(input int u, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err);
        int depth = (u == 0) ? DEPTH_A : DEPTH_B;
        int size;
        rdata = 32'd0;
        err   = 1'b0;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default: begin size = 4; err = 1'b1; end
        endcase
        if (we && f3[2]) err = 1'b1;
        if ((addr % size) != 0) err = 1'b1;
        if ((addr >> 2) >= depth) err = 1'b1;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < size; i++) mdl[u][addr + i] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < size; i++) rdata[8*i +: 8] = mdl[u][addr + i];
                if (!f3[2] && size < 4 && rdata[8*size-1])
                    rdata = rdata | ~((32'd1 << (8*size)) - 32'd1);
            end
        end
    endtask

    function automatic logic [2:0] gen_f3();
        logic [2:0] f;
        case ($urandom_range(0, 7))
            0, 1: f = 3'd0;
            2:    f = 3'd4;
            3:    f = 3'd1;
            4:    f = 3'd5;
            5, 6: f = 3'd2;
            default: f = 3'($urandom);
        endcase
        return f;
    endfunction

    function automatic logic [31:0] gen_addr(input int span, input int oor_base, input logic [2:0] f3);
        logic [31:0] a;
        if ($urandom_range(0, 15) == 0) a = 32'(oor_base + $urandom_range(0, 15));
        else a = 32'($urandom_range(0, span - 1));
        if ($urandom_range(0, 3) != 0) begin
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            else if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
        end
        return a;
    endfunction

    // Drives one access into instance A and reports what came back.
    task automatic acc_a(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat, output bit hold_ok);
        int   n = 0;
        logic st_r, rdy_r;
        rdata = 32'd0; err = 1'b0; lat = -1; hold_ok = 1'b0;
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = we; a_req_funct3 = f3;
        a_req_addr = addr; a_req_wdata = wdata;
        while (a_req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (a_req_ready === 1'b1) begin
            @(posedge clk); #1;
            a_req_valid = 1'b0; a_req_we = 1'($urandom); a_req_funct3 = 3'($urandom);
            a_req_addr = $urandom; a_req_wdata = $urandom;
            lat = 0;
            do begin @(negedge clk); lat++; end while (a_rsp_valid !== 1'b1 && lat < 20);
            if (a_rsp_valid !== 1'b1) begin
                lat = -1;
            end else begin
                rdata = a_rsp_rdata; err = a_rsp_err; st_r = a_stall; rdy_r = a_req_ready;
                @(negedge clk);
                hold_ok = (st_r === 1'b1 && rdy_r === 1'b0 && a_rsp_valid === 1'b0 &&
                           a_rsp_rdata === rdata && a_rsp_err === err &&
                           a_stall === 1'b0 && a_req_ready === 1'b1);
            end
        end else begin
            a_req_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({a_req_ready, a_rsp_valid, a_stall, a_rsp_err, a_rsp_rdata} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_a_outputs: got rdy=%b v=%b st=%b err=%b rd=%h, want all zero",
                     a_req_ready, a_rsp_valid, a_stall, a_rsp_err, a_rsp_rdata);
        end
        n_checks++;
        if ({b_req_ready, b_rsp_valid, b_stall, b_rsp_err, b_rsp_rdata} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_b_outputs: got rdy=%b v=%b st=%b err=%b rd=%h, want all zero",
                     b_req_ready, b_rsp_valid, b_stall, b_rsp_err, b_rsp_rdata);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (a_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: got %b, want 0", a_req_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({a_req_ready, b_req_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL ready_after_edge: got a=%b b=%b, want 1 1", a_req_ready, b_req_ready);
        end
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } step_t;

    task automatic test_directed();
        step_t       steps[$];
        logic [31:0] rd, mrd;
        logic        er, mer;
        int          lat;
        bit          hold;
        steps.push_back('{"sw_deadbeef",  1'b1, 3'd2, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0});
        steps.push_back('{"lw_10",        1'b0, 3'd2, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0});
        steps.push_back('{"sb_80",        1'b1, 3'd0, 32'h13,   32'hFFFFFF80, 32'h0,        1'b0});
        steps.push_back('{"lb_13",        1'b0, 3'd0, 32'h13,   32'h0,        32'hFFFFFF80, 1'b0});
        steps.push_back('{"lbu_13",       1'b0, 3'd4, 32'h13,   32'h0,        32'h00000080, 1'b0});
        steps.push_back('{"lw_after_sb",  1'b0, 3'd2, 32'h10,   32'h0,        32'h80ADBEEF, 1'b0});
        steps.push_back('{"sh_1234",      1'b1, 3'd1, 32'h12,   32'hABCD1234, 32'h0,        1'b0});
        steps.push_back('{"lhu_12",       1'b0, 3'd5, 32'h12,   32'h0,        32'h00001234, 1'b0});
        steps.push_back('{"lh_misalign",  1'b0, 3'd1, 32'h11,   32'h0,        32'h0,        1'b1});
        steps.push_back('{"lw_after_sh",  1'b0, 3'd2, 32'h10,   32'h0,        32'h1234BEEF, 1'b0});
        steps.push_back('{"sw_misalign",  1'b1, 3'd2, 32'h12,   32'h11111111, 32'h0,        1'b1});
        steps.push_back('{"sbu_illegal",  1'b1, 3'd4, 32'h10,   32'h22222222, 32'h0,        1'b1});
        steps.push_back('{"ld_f3_011",    1'b0, 3'd3, 32'h10,   32'h0,        32'h0,        1'b1});
        steps.push_back('{"lw_unchanged", 1'b0, 3'd2, 32'h10,   32'h0,        32'h1234BEEF, 1'b0});
        steps.push_back('{"sw_oor",       1'b1, 3'd2, 32'(DEPTH_A*4), 32'hCAFEF00D, 32'h0, 1'b1});
        steps.push_back('{"lw_oor",       1'b0, 3'd2, 32'(DEPTH_A*4), 32'h0,  32'h0,        1'b1});
        steps.push_back('{"lw_0",         1'b0, 3'd2, 32'h0,    32'h0,        32'h0,        1'b0});
        foreach (steps[i]) begin
            acc_a(steps[i].we, steps[i].f3, steps[i].addr, steps[i].wdata, rd, er, lat, hold);
            model_access(0, steps[i].we, steps[i].f3, steps[i].addr, steps[i].wdata, mrd, mer);
            n_checks++;
            if (rd !== steps[i].rdata) begin
                n_fail++;
                $display("FAIL %s rdata: got %h, want %h", steps[i].name, rd, steps[i].rdata);
            end
            n_checks++;
            if (er !== steps[i].err) begin
                n_fail++;
                $display("FAIL %s err: got %b, want %b", steps[i].name, er, steps[i].err);
            end
            n_checks++;
            if (lat !== WAIT_A + 1) begin
                n_fail++;
                $display("FAIL %s latency: got %0d, want %0d", steps[i].name, lat, WAIT_A + 1);
            end
            n_checks++;
            if (hold !== 1'b1) begin
                n_fail++;
                $display("FAIL %s hold/stall: got %b, want 1", steps[i].name, hold);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        er;
        int          lat, n;
        bit          hold, seen;
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_funct3 = 3'd2;
        a_req_addr = 32'h20; a_req_wdata = 32'h55;
        n = 0;
        while (a_req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_wait_stall: got %b, want 1", a_stall);
        end
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if ({a_req_ready, a_rsp_valid, a_stall, a_rsp_err, a_rsp_rdata} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: got rdy=%b v=%b st=%b err=%b rd=%h, want all zero",
                     a_req_ready, a_rsp_valid, a_stall, a_rsp_err, a_rsp_rdata);
        end
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (a_rsp_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_no_rsp: got rsp_valid seen=%b, want 0", seen);
        end
        @(negedge clk);
        rst = 1'b1;
        acc_a(1'b0, 3'd2, 32'h20, 32'h0, rd, er, lat, hold);
        n_checks++;
        if ({er, rd} !== 33'd0 || lat !== WAIT_A + 1) begin
            n_fail++;
            $display("FAIL reset_mid_lw20: got rd=%h err=%b lat=%0d, want 0 0 %0d",
                     rd, er, lat, WAIT_A + 1);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, mrd, addr, wd;
        logic        er, mer, we;
        logic [2:0]  f3;
        int          lat;
        bit          hold;
        for (int i = 0; i < 150; i++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = gen_f3();
            addr = gen_addr(64, DEPTH_A * 4, f3);
            wd   = $urandom;
            acc_a(we, f3, addr, wd, rd, er, lat, hold);
            model_access(0, we, f3, addr, wd, mrd, mer);
            n_checks++;
            if (rd !== mrd || er !== mer) begin
                n_fail++;
                $display("FAIL rand_a[%0d] we=%b f3=%0d addr=%h: got rd=%h err=%b, want rd=%h err=%b",
                         i, we, f3, addr, rd, er, mrd, mer);
            end
            n_checks++;
            if (lat !== WAIT_A + 1 || hold !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_a[%0d] timing: got lat=%0d hold=%b, want %0d 1",
                         i, lat, hold, WAIT_A + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit          exp_acc = 1'b0, nxt;
        logic [2:0]  exp_hs;
        logic [31:0] pend_rd = 32'd0;
        logic        pend_er = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            exp_hs = exp_acc ? 3'b110 : 3'b001;
            n_checks++;
            if ({b_rsp_valid, b_stall, b_req_ready} !== exp_hs) begin
                n_fail++;
                $display("FAIL b2b[%0d] valid/stall/ready: got %b, want %b",
                         c, {b_rsp_valid, b_stall, b_req_ready}, exp_hs);
            end
            if (exp_acc) begin
                n_checks++;
                if (b_rsp_rdata !== pend_rd || b_rsp_err !== pend_er) begin
                    n_fail++;
                    $display("FAIL b2b[%0d] data: got rd=%h err=%b, want rd=%h err=%b",
                             c, b_rsp_rdata, b_rsp_err, pend_rd, pend_er);
                end
            end
            b_req_valid  = 1'b1;
            b_req_we     = 1'($urandom_range(0, 1));
            b_req_funct3 = gen_f3();
            b_req_addr   = gen_addr(DEPTH_B * 4, DEPTH_B * 4, b_req_funct3);
            b_req_wdata  = $urandom;
            nxt = !exp_acc;
            if (nxt) model_access(1, b_req_we, b_req_funct3, b_req_addr, b_req_wdata, pend_rd, pend_er);
            exp_acc = nxt;
        end
        @(negedge clk);
        b_req_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 1024: number of 32-bit words; power of two, at least 4.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: wait states per access, range 0..15.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset; rst=0 resets immediately, independent of clk.
REQ-005 SHALL have port req_valid  input  1  access request present.
REQ-006 SHALL have port req_ready  output  1  unit can accept a request.
REQ-007 SHALL have port req_we  input  1  1=store, 0=load.
REQ-008 SHALL have port req_funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, LSB-aligned.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle response pulse.
REQ-012 SHALL have port rsp_rdata  output  32  extended load data.
REQ-013 SHALL have port rsp_err  output  1  access faulted; valid with rsp_valid.
REQ-014 SHALL have port stall  output  1  pipeline hold; high while an access is in flight.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready=1 only in IDLE; stall=1 in WAIT and RESP.
REQ-016 SHALL accept a request on a rising edge with req_valid=1 and req_ready=1, and latch we, funct3, addr, wdata; request inputs are ignored at all other times.
REQ-017 SHALL go IDLE->WAIT on accept when WAIT_CYCLES>0, staying exactly WAIT_CYCLES cycles in WAIT; when WAIT_CYCLES=0, SHALL go IDLE->RESP directly.
REQ-018 SHALL hold RESP for exactly one cycle with rsp_valid=1, then return to IDLE; rsp_valid is 0 in every other state.
REQ-019 SHALL raise rsp_valid WAIT_CYCLES+1 cycles after the accept edge; back-to-back throughput SHALL be one access per WAIT_CYCLES+2 cycles.
REQ-020 SHALL index the word array with addr[31:2].
REQ-021 SHALL perform a store on the edge entering RESP, writing only the enabled byte lanes:
- B: lane addr[1:0], data wdata[7:0]
- H: lanes addr[1]*2 and addr[1]*2+1, data wdata[15:0]
- W: all four lanes
Non-enabled lanes SHALL keep their old contents.
REQ-022 SHALL sample load data on the edge entering RESP and select the lane as in REQ-021:
- funct3 000 sign-extends the byte; 100 zero-extends it
- 001 sign-extends the halfword; 101 zero-extends it
- 010 returns the whole word
REQ-023 SHALL flag rsp_err=1 for any of:
- halfword access with addr[0]=1
- word access with addr[1:0]!=0
- addr[31:2] >= DEPTH
- funct3 outside the set in REQ-008, or store with funct3 100/101
REQ-024 SHALL, on a faulted access, suppress the memory write and return rsp_rdata=0.
REQ-025 SHALL return rsp_rdata=0 for every store response.
REQ-026 SHALL hold rsp_rdata and rsp_err stable from a response until the next response.
REQ-027 SHALL make a load issued after a store to the same word return the post-store data (no stale read).
REQ-028 SHALL initialise the memory array to all zeros at time zero; reset SHALL NOT clear the array.

Reset
REQ-029 SHALL, while rst=0, force state IDLE, wait counter 0, rsp_valid=0, rsp_rdata=0, rsp_err=0, stall=0, and req_ready=0.
REQ-030 SHALL drive req_ready=1 from the first rising clk edge after rst returns to 1.
REQ-031 SHALL discard an in-flight access when reset is asserted during WAIT or RESP: no memory write and no response.

Verification
REQ-032 SHALL check, WAIT_CYCLES=2: SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_valid 3 cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-033 SHALL check: SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
REQ-034 SHALL check: SH 0x1234 @0x12, then LHU @0x12 -> 0x00001234; LH @0x11 -> err 1, rdata 0; LW @0x10 -> 0x1234BEEF unchanged by the faulted access.
REQ-035 SHALL check: SW @DEPTH*4 -> err 1, memory unchanged; LW @0x0 -> 0x00000000.
REQ-036 SHALL check: rst=0 mid-WAIT on SW 0x55 @0x20 -> outputs cleared at once, no response; LW @0x20 after release -> 0x00000000.
REQ-037 SHALL check, WAIT_CYCLES=0: continuous req_valid -> one rsp_valid every 2 cycles, stall=1 between accepts.
